// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: PDM mic clock generation, session sequencing and bit-count decimation to PCM samples
module pdm_mic_ctrl #(
    parameter int HALF   = 25,
    parameter int WARMUP = 16,
    parameter int DECIM  = 64,
    parameter int SW     = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          mic_data,
    output logic          mic_clk,
    output logic [SW-1:0] sample,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          busy,
    output logic          overrun,
    output logic          led
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WARM = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam int BW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(DECIM + 1);
    localparam logic [15:0]   HALF_M1 = 16'(HALF - 1);
    localparam logic [15:0]   WARM_M1 = 16'(WARMUP - 1);
    localparam logic [BW-1:0] DEC_M1  = BW'(DECIM - 1);

    logic [1:0]    state_q, state_d;
    logic [15:0]   hcnt_q, hcnt_d;
    logic [15:0]   warm_q, warm_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [SW-1:0] sample_q, sample_d;
    logic          mclk_q, mclk_d;
    logic          mclk_p_q;
    logic          sync1_q, sync2_q;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          stop_pend_q, stop_pend_d;
    logic          wrap, fall, win_done;
    logic [AW-1:0] result;

    // Next-state logic: mic clock divider, warm-up/capture sequencing, accumulation and output handshake
    always_comb begin
        wrap        = hcnt_q == HALF_M1;
        fall        = (state_q != S_IDLE) && mclk_p_q && !mclk_q;
        win_done    = (state_q == S_CAP) && fall && (bcnt_q == DEC_M1);
        result      = acc_q + AW'(sync2_q);
        state_d     = state_q;
        hcnt_d      = wrap ? 16'd0 : hcnt_q + 16'd1;
        mclk_d      = mclk_q ^ wrap;
        warm_d      = warm_q;
        bcnt_d      = bcnt_q;
        acc_d       = acc_q;
        stop_pend_d = stop_pend_q;
        sample_d    = sample_q;
        valid_d     = valid_q && !sample_ready;
        overrun_d   = overrun_q;
        if (state_q == S_IDLE) begin
            hcnt_d      = 16'd0;
            mclk_d      = 1'b0;
            warm_d      = 16'd0;
            bcnt_d      = '0;
            acc_d       = '0;
            stop_pend_d = 1'b0;
            if (start) begin
                state_d   = S_WARM;
                overrun_d = 1'b0;
            end
        end else if (state_q == S_WARM) begin
            if (fall) begin
                warm_d = warm_q + 16'd1;
                if (warm_q == WARM_M1) begin
                    state_d = S_CAP;
                    bcnt_d  = '0;
                    acc_d   = '0;
                end
            end
            if (stop) state_d = S_IDLE;
        end else begin
            stop_pend_d = stop_pend_q || stop;
            if (fall) begin
                bcnt_d = bcnt_q + 1'b1;
                acc_d  = result;
            end
            if (win_done) begin
                bcnt_d = '0;
                acc_d  = '0;
                if (stop || stop_pend_q) state_d = S_IDLE;
            end
        end
        if (win_done) begin
            if (!valid_q || sample_ready) begin
                sample_d = SW'(result);
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (state_d == S_IDLE) begin
            hcnt_d = 16'd0;
            mclk_d = 1'b0;
        end
    end

    // State registers, including the mic_data synchronizer and the delayed mic_clk for fall detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hcnt_q      <= 16'd0;
            warm_q      <= 16'd0;
            bcnt_q      <= '0;
            acc_q       <= '0;
            sample_q    <= '0;
            mclk_q      <= 1'b0;
            mclk_p_q    <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            warm_q      <= warm_d;
            bcnt_q      <= bcnt_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            mclk_q      <= mclk_d;
            mclk_p_q    <= mclk_q;
            sync1_q     <= mic_data;
            sync2_q     <= sync1_q;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign mic_clk      = mclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign busy         = state_q != S_IDLE;
    assign led          = busy;
endmodule
